// File: rtl/branch_predict_if.sv
// Fetch/resolve bundle between the pipeline and the branch predictor.
// No handshake: resolve_valid is a one-cycle pulse per resolved instruction, back-to-back pulses allowed.
interface branch_predict_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  stall;
  logic                  resolve_valid;
  logic [1:0]            resolve_branch_op;
  logic [ADDR_WIDTH-1:0] resolve_instr_addr;
  logic [ADDR_WIDTH-1:0] resolve_base;
  logic [ADDR_WIDTH-1:0] resolve_offset;
  logic                  resolve_alu_zero;
  logic                  resolve_pred_taken;
  logic [ADDR_WIDTH-1:0] resolve_pred_target;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pred_taken;
  logic [ADDR_WIDTH-1:0] pred_target;
  logic                  mispredict;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [CNT_WIDTH-1:0]  mispredict_count;

  modport master (
    output stall, resolve_valid, resolve_branch_op, resolve_instr_addr,
           resolve_base, resolve_offset, resolve_alu_zero,
           resolve_pred_taken, resolve_pred_target,
    input  pc, pred_taken, pred_target, mispredict, redirect_pc, mispredict_count
  );

  modport slave (
    input  stall, resolve_valid, resolve_branch_op, resolve_instr_addr,
           resolve_base, resolve_offset, resolve_alu_zero,
           resolve_pred_taken, resolve_pred_target,
    output pc, pred_taken, pred_target, mispredict, redirect_pc, mispredict_count
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Registered next-PC generator with a direct-mapped BTB and 2-bit direction counters,
// trained and redirected by branches resolved in execute.
module branch_predict_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    BTB_DEPTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic            clk,
  input  logic            reset,
  branch_predict_if.slave bus
);
  localparam int IDX_BITS = $clog2(BTB_DEPTH);
  localparam int TAG_W    = ADDR_WIDTH - IDX_BITS - 2;

  logic                  valid_q  [BTB_DEPTH];
  logic                  valid_d  [BTB_DEPTH];
  logic [TAG_W-1:0]      tag_q    [BTB_DEPTH];
  logic [TAG_W-1:0]      tag_d    [BTB_DEPTH];
  logic [ADDR_WIDTH-1:0] target_q [BTB_DEPTH];
  logic [ADDR_WIDTH-1:0] target_d [BTB_DEPTH];
  logic [1:0]            ctr_q    [BTB_DEPTH];
  logic [1:0]            ctr_d    [BTB_DEPTH];

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [IDX_BITS-1:0]   f_idx, r_idx;
  logic [TAG_W-1:0]      f_tag, r_tag;
  logic                  f_hit, r_hit;
  logic                  pred_taken;
  logic [ADDR_WIDTH-1:0] pred_target;
  logic                  actual_taken;
  logic [ADDR_WIDTH-1:0] actual_target;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  mispredict;
  logic                  train;

  // Fetch-side lookup reads the registered table, so a same-cycle write is not visible yet.
  always_comb begin
    f_idx       = pc_q[IDX_BITS+1:2];
    f_tag       = pc_q[ADDR_WIDTH-1:IDX_BITS+2];
    f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken  = f_hit && ctr_q[f_idx][1];
    pred_target = f_hit ? target_q[f_idx] : pc_q + ADDR_WIDTH'(4);
  end

  always_comb begin
    actual_taken  = (bus.resolve_branch_op[0] && !bus.resolve_alu_zero) ||
                    (bus.resolve_branch_op[1] &&  bus.resolve_alu_zero);
    actual_target = bus.resolve_base + bus.resolve_offset;
    redirect_pc   = actual_taken ? actual_target : bus.resolve_instr_addr + ADDR_WIDTH'(4);
    mispredict    = bus.resolve_valid && !reset &&
                    ((actual_taken != bus.resolve_pred_taken) ||
                     (actual_taken && (actual_target != bus.resolve_pred_target)));
  end

  always_comb begin
    pc_d = pc_q + ADDR_WIDTH'(4);
    if (mispredict)      pc_d = redirect_pc;
    else if (bus.stall)  pc_d = pc_q;
    else if (pred_taken) pc_d = pred_target;

    cnt_d = cnt_q;
    if (mispredict && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // Op 00 never trains, so a stale alias is corrected by redirect only.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    r_idx    = bus.resolve_instr_addr[IDX_BITS+1:2];
    r_tag    = bus.resolve_instr_addr[ADDR_WIDTH-1:IDX_BITS+2];
    r_hit    = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    train    = bus.resolve_valid && (bus.resolve_branch_op != 2'b00) && !reset;
    if (train) begin
      if (r_hit) begin
        if (actual_taken) begin
          ctr_d[r_idx]    = (ctr_q[r_idx] == 2'b11) ? 2'b11 : ctr_q[r_idx] + 2'd1;
          target_d[r_idx] = actual_target;
        end else begin
          ctr_d[r_idx]    = (ctr_q[r_idx] == 2'b00) ? 2'b00 : ctr_q[r_idx] - 2'd1;
        end
      end else if (actual_taken) begin
        valid_d[r_idx]  = 1'b1;
        tag_d[r_idx]    = r_tag;
        target_d[r_idx] = actual_target;
        ctr_d[r_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.pred_taken       = pred_taken;
  assign bus.pred_target      = pred_target;
  assign bus.mispredict       = mispredict;
  assign bus.redirect_pc      = redirect_pc;
  assign bus.mispredict_count = cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed test-plan steps followed by random resolves, checked against an array-based predictor model.
module tb_branch_predict_unit;
  localparam int          AW    = 32;
  localparam int          DEPTH = 16;
  localparam int          CW    = 2;
  localparam logic [31:0] RPC   = 32'h100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predict_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  branch_predict_unit #(
    .ADDR_WIDTH(AW), .BTB_DEPTH(DEPTH), .RESET_PC(RPC), .CNT_WIDTH(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          known = 1'b0;
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_v   [DEPTH];
  logic [31:0] m_tag [DEPTH];
  logic [31:0] m_tgt [DEPTH];
  int          m_ctr [DEPTH];

  // Values captured before the edge, applied after it
  bit          p_rst, p_mp, p_train, p_at;
  logic [31:0] p_npc, p_tgt, p_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void lookup(input logic [31:0] a, output bit tk, output logic [31:0] tg);
    int i;
    bit hit;
    i   = int'((a >> 2) % DEPTH);
    hit = m_v[i] && (m_tag[i] == (a >> 6));
    tk  = hit && (m_ctr[i] >= 2);
    tg  = hit ? m_tgt[i] : a + 32'd4;
  endfunction

  task automatic step(input bit r, input bit st, input bit rv, input logic [1:0] op,
                      input logic [31:0] addr, input logic [31:0] base, input logic [31:0] off,
                      input bit z, input bit ptk, input logic [31:0] ptgt);
    bit          at, mp, ftk;
    logic [31:0] tgt, rdr, ftg;
    reset                   = r;
    bus.stall               = st;
    bus.resolve_valid       = rv;
    bus.resolve_branch_op   = op;
    bus.resolve_instr_addr  = addr;
    bus.resolve_base        = base;
    bus.resolve_offset      = off;
    bus.resolve_alu_zero    = z;
    bus.resolve_pred_taken  = ptk;
    bus.resolve_pred_target = ptgt;
    #1;
    at  = (op[0] && !z) || (op[1] && z);
    tgt = base + off;
    rdr = at ? tgt : addr + 32'd4;
    mp  = rv && !r && ((at != ptk) || (at && (tgt != ptgt)));
    chk("redirect_pc", bus.redirect_pc, rdr);
    chk("mispredict", {31'b0, bus.mispredict}, {31'b0, mp});
    if (known) begin
      lookup(m_pc, ftk, ftg);
      chk("pc", bus.pc, m_pc);
      chk("pred_taken", {31'b0, bus.pred_taken}, {31'b0, ftk});
      chk("pred_target", bus.pred_target, ftg);
      chk("count", {30'b0, bus.mispredict_count}, m_cnt);
      if (r)       p_npc = RPC;
      else if (mp) p_npc = rdr;
      else if (st) p_npc = m_pc;
      else if (ftk) p_npc = ftg;
      else         p_npc = m_pc + 32'd4;
    end else begin
      p_npc = RPC;
    end
    p_rst   = r;
    p_mp    = mp;
    p_train = rv && (op != 2'b00) && !r;
    p_at    = at;
    p_tgt   = tgt;
    p_addr  = addr;
  endtask

  task automatic tick();
    int  i;
    bit  hit;
    @(posedge clk);
    #1;
    m_pc = p_npc;
    if (p_rst) begin
      known = 1'b1;
      m_cnt = 0;
      for (int k = 0; k < DEPTH; k++) begin
        m_v[k]   = 1'b0;
        m_ctr[k] = 1;
      end
    end else begin
      if (p_mp) m_cnt = (m_cnt + 1 > 3) ? 3 : m_cnt + 1;
      if (p_train) begin
        i   = int'((p_addr >> 2) % DEPTH);
        hit = m_v[i] && (m_tag[i] == (p_addr >> 6));
        if (hit) begin
          m_ctr[i] = p_at ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                          : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
          if (p_at) m_tgt[i] = p_tgt;
        end else if (p_at) begin
          m_v[i]   = 1'b1;
          m_tag[i] = p_addr >> 6;
          m_tgt[i] = p_tgt;
          m_ctr[i] = 2;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit st);
    step(1'b0, st, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
  endtask

  // Non-branch resolve claiming "taken" forces a redirect to a+4.
  task automatic jump_to(input logic [31:0] a);
    step(1'b0, 1'b0, 1'b1, 2'b00, a - 32'd4, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    tick();
  endtask

  initial begin
    bit          rtk;
    logic [31:0] rtg, ra;
    logic [1:0]  rop;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("rst_pc", bus.pc, 32'h100);
    chk("rst_pred_taken", {31'b0, bus.pred_taken}, 32'h0);
    chk("rst_pred_target", bus.pred_target, 32'h104);
    chk("rst_count", {30'b0, bus.mispredict_count}, 32'h0);
    idle(1'b0);
    idle(1'b0);
    chk("seq_pc", bus.pc, 32'h108);

    // Taken branch at 0x104 allocates entry 1
    step(1'b0, 1'b0, 1'b1, 2'b11, 32'h104, 32'h104, 32'h20, 1'b0, 1'b0, 32'h0);
    chk("alloc_mp", {31'b0, bus.mispredict}, 32'h1);
    chk("alloc_redirect", bus.redirect_pc, 32'h124);
    tick();
    chk("alloc_pc", bus.pc, 32'h124);
    jump_to(32'h104);
    chk("hit_taken", {31'b0, bus.pred_taken}, 32'h1);
    chk("hit_target", bus.pred_target, 32'h124);

    // Not taken while fetching 0x104: same-cycle lookup still sees the old counter
    step(1'b0, 1'b0, 1'b1, 2'b10, 32'h104, 32'h104, 32'h20, 1'b0, 1'b1, 32'h124);
    chk("nt_mp", {31'b0, bus.mispredict}, 32'h1);
    chk("nt_redirect", bus.redirect_pc, 32'h108);
    chk("old_pred", {31'b0, bus.pred_taken}, 32'h1);
    tick();
    chk("nt_pc", bus.pc, 32'h108);
    jump_to(32'h104);
    chk("weak_nt", {31'b0, bus.pred_taken}, 32'h0);
    chk("weak_nt_tgt", bus.pred_target, 32'h124);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b1, 2'b10, 32'h104, 32'h104, 32'h20, 1'b0, 1'b0, 32'h0);
      chk("nt_no_mp", {31'b0, bus.mispredict}, 32'h0);
      tick();
    end
    // Counter at 00: one taken only reaches 01
    step(1'b0, 1'b0, 1'b1, 2'b11, 32'h104, 32'h104, 32'h20, 1'b0, 1'b0, 32'h0);
    tick();
    jump_to(32'h104);
    chk("sat_low", {31'b0, bus.pred_taken}, 32'h0);

    // Alias at 0x144 shares index 1
    jump_to(32'h144);
    chk("alias_taken", {31'b0, bus.pred_taken}, 32'h0);
    chk("alias_target", bus.pred_target, 32'h148);
    step(1'b0, 1'b0, 1'b1, 2'b11, 32'h144, 32'h144, 32'h40, 1'b0, 1'b0, 32'h0);
    tick();
    jump_to(32'h144);
    chk("alias_hit", {31'b0, bus.pred_taken}, 32'h1);
    chk("alias_hit_tgt", bus.pred_target, 32'h184);
    jump_to(32'h104);
    chk("evicted", {31'b0, bus.pred_taken}, 32'h0);
    chk("evicted_tgt", bus.pred_target, 32'h108);

    // Mispredict overrides stall; stall alone holds
    step(1'b0, 1'b1, 1'b1, 2'b00, 32'h200, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    tick();
    chk("mp_over_stall", bus.pc, 32'h204);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      chk("stall_hold", bus.pc, 32'h204);
    end

    // Saturating counter
    step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b1, 2'b00, 32'h300 + 32'(k * 8), 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
      tick();
      chk("count_sat", {30'b0, bus.mispredict_count}, (k < 3) ? k + 1 : 3);
    end
    step(1'b1, 1'b0, 1'b1, 2'b11, 32'h104, 32'h104, 32'h20, 1'b0, 1'b0, 32'h0);
    chk("rst_resolve_mp", {31'b0, bus.mispredict}, 32'h0);
    tick();
    chk("rst_resolve_cnt", {30'b0, bus.mispredict_count}, 32'h0);
    idle(1'b0);
    chk("rst_resolve_pc", bus.pc, 32'h104);
    chk("rst_no_train", {31'b0, bus.pred_taken}, 32'h0);

    // Random resolves over a small aliasing address window
    for (int n = 0; n < 500; n++) begin
      ra  = 32'h100 + 32'($urandom_range(0, 39) * 4);
      rop = 2'($urandom_range(0, 3));
      lookup(ra, rtk, rtg);
      if ($urandom_range(0, 1) == 1) begin
        rtk = 1'($urandom_range(0, 1));
        rtg = 32'h100 + 32'($urandom_range(0, 63) * 4);
      end
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) != 0), rop, ra, ra,
           32'($urandom_range(0, 15) * 4) - 32'h20,
           1'($urandom_range(0, 1)), rtk, rtg);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised next-PC generator that replaces the purely combinational PC+4 / branch-target select with a registered program counter, a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. The fetch stage reads `pc` and the predicted direction each cycle. The execute stage returns resolved branches on a resolve port; the block detects mispredictions, redirects `pc`, and trains the table. It sits between instruction fetch and the execute-stage branch resolution logic.

## Interface
- `ADDR_WIDTH`, 32: address/data width; must be ≥ IDX_BITS+3.
- `BTB_DEPTH`, 16: BTB entries; power of two, ≥ 2. IDX_BITS = log2(BTB_DEPTH).
- `RESET_PC`, 0: `pc` value after reset; word-aligned.
- `CNT_WIDTH`, 16: misprediction counter width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold `pc` (ignored on a redirect).
- `resolve_valid` in 1: a resolved instruction is presented this cycle.
- `resolve_branch_op` in 2: 00 not a branch, 01 taken if ALU result ≠ 0, 10 taken if ALU result = 0, 11 always taken.
- `resolve_instr_addr` in ADDR_WIDTH: address of the resolved instruction.
- `resolve_base`, `resolve_offset` in ADDR_WIDTH: the target is base + offset, modulo 2^ADDR_WIDTH.
- `resolve_alu_zero` in 1: ALU result is zero.
- `resolve_pred_taken` in 1, `resolve_pred_target` in ADDR_WIDTH: the prediction that was made for this instruction, carried down the pipeline.
- `pc` out ADDR_WIDTH: current fetch address (registered).
- `pred_taken` out 1, `pred_target` out ADDR_WIDTH: prediction for `pc` (combinational from the table).
- `mispredict` out 1, `redirect_pc` out ADDR_WIDTH: combinational resolve outcome.
- `mispredict_count` out CNT_WIDTH: saturating count of mispredictions.

## Operation
- Entry fields: `valid`, `tag` = addr[ADDR_WIDTH-1:IDX_BITS+2], `target`, 2-bit `ctr`.
- Entry index = addr[IDX_BITS+1:2].
- Lookup: hit = valid AND tag match at index(pc).
  - `pred_taken` = hit AND ctr[1].
  - `pred_target` = target on a hit, else pc+4.
- Resolve:
  - actual_taken = (op[0] AND NOT zero) OR (op[1] AND zero).
  - actual_target = base + offset.
  - `redirect_pc` = actual_taken ? actual_target : resolve_instr_addr+4.
- `mispredict` = resolve_valid AND NOT reset AND (actual_taken ≠ resolve_pred_taken OR (actual_taken AND actual_target ≠ resolve_pred_target)).
- Next `pc`, in priority order:
  1. reset → RESET_PC.
  2. mispredict → redirect_pc (overrides stall).
  3. stall → hold.
  4. pred_taken → pred_target.
  5. otherwise → pc+4, wrapping modulo 2^ADDR_WIDTH.
- Training happens only when resolve_valid is high, op ≠ 00 and reset is low.
  - Hit at index(resolve_instr_addr): ctr increments if taken, decrements if not, saturating at 11 and 00. Target is written only if taken.
  - Miss and taken: allocate the entry, overwriting any existing one. Set valid=1, new tag, target=actual_target, ctr=10.
  - Miss and not taken: no write.
- op = 00: never trains. It can still mispredict if resolve_pred_taken=1, which lets the pipeline recover from a stale BTB alias.
- `mispredict_count` increments on each mispredict cycle and saturates at all-ones.

## Timing
- Reset, one cycle:
  - `pc`=RESET_PC.
  - All valid=0, all ctr=01.
  - `mispredict_count`=0.
  - Hence `pred_taken`=0, `pred_target`=RESET_PC+4, `mispredict`=0.
- Lookup latency is 0 cycles: a prediction is available in the same cycle as `pc`.
- A redirect lands in `pc` one cycle after `mispredict` is asserted.
- A table write takes effect at the edge. A same-cycle lookup of the same index sees the old contents; the next cycle sees the new contents.
- Reset mid-stream discards any concurrent resolve: no training, no count.
- No handshake: resolve is a one-cycle valid pulse per instruction, and back-to-back resolves are supported.

## Test plan
- Reset with RESET_PC=0x100, stall=0 → pc sequence 0x100, 0x104, 0x108; pred_taken=0 throughout.
- Resolve op=11, addr=0x104, base=0x104, offset=0x20, pred_taken=0 → mispredict=1, redirect_pc=0x124; next pc=0x124. Entry 1 holds target 0x124, ctr=10. Next fetch of 0x104 predicts taken to 0x124.
- Same branch resolved with op=10, zero=0, pred_taken=1 → mispredict=1, redirect_pc=0x108, ctr 10→01; a later fetch of 0x104 predicts not-taken. Four consecutive not-taken resolves leave ctr at 00 (saturates).
- Alias, BTB_DEPTH=16: a taken branch at 0x104, then a fetch of 0x144 (same index, different tag) → pred_taken=0. Resolving 0x144 taken replaces the entry; 0x104 then misses.
- mispredict and stall both high → pc loads redirect_pc. A stall alone holds pc for 3 cycles.
- With CNT_WIDTH=2, drive 5 mispredicts → mispredict_count reads 1, 2, 3, 3, 3. Reset asserted alongside resolve_valid → no table change and count=0.
